// File: rtl/msrv32_imm_encoder.sv
// ---------------------------------------------------------------------------
// msrv32_imm_encoder
//   Packs a 32-bit immediate into the immediate fields of a RISC-V base
//   instruction. This is the inverse of the decode-side immediate generator.
//   Type 111 can instead expand a "load immediate" into ADDI, or into LUI
//   followed by ADDI. The block feeds self-test ROM builders and trace replay.
//
// Parameters
//   LI_EN  1: type 111 is LI expansion; 0: type 111 is encoded as I-type
//
// Ports
//   ms_riscv32_mp_clk_in  in   clock, all state on the rising edge
//   ms_riscv32_mp_rst_in  in   synchronous active-high reset
//   req_valid_in          in   request valid
//   req_ready_out         out  request accepted when valid & ready
//   imm_in[31:0]          in   immediate value (byte offset for B/J)
//   imm_type_in[2:0]      in   000/001 I, 010 S, 011 B, 100 U, 101 J,
//                              110 CSR uimm, 111 LI
//   base_instr_in[31:0]   in   instruction template; non-immediate bits pass
//   instr_valid_out       out  output instruction valid
//   instr_ready_in        in   consumer accepts when valid & ready
//   instr_out[31:0]       out  encoded instruction
//   instr_last_out        out  last instruction of this request
//   range_err_out         out  immediate not representable for the type
// ---------------------------------------------------------------------------
module msrv32_imm_encoder #(
    parameter bit LI_EN = 1'b1
) (
    input  logic        ms_riscv32_mp_clk_in,
    input  logic        ms_riscv32_mp_rst_in,
    input  logic        req_valid_in,
    output logic        req_ready_out,
    input  logic [31:0] imm_in,
    input  logic [2:0]  imm_type_in,
    input  logic [31:0] base_instr_in,
    output logic        instr_valid_out,
    input  logic        instr_ready_in,
    output logic [31:0] instr_out,
    output logic        instr_last_out,
    output logic        range_err_out
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        OUT_LUI  = 2'd1,
        OUT_LAST = 2'd2
    } state_t;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    // True when v[31:lsb] are all zeros or all ones (sign-extendable field).
    function automatic logic upper_uniform(input logic [31:0] v, input int unsigned lsb);
        logic [31:0] s;
        s = 32'($signed(v) >>> lsb);
        return (s == 32'h0000_0000) || (s == 32'hFFFF_FFFF);
    endfunction

    state_t      state_r, state_s;
    logic        valid_r, valid_s;
    logic [31:0] instr_r, instr_s;
    logic        last_r, last_s;
    logic        err_r, err_s;
    logic [31:0] pend_r, pend_s;

    logic [31:0] enc_first_s;
    logic        enc_err_s;
    logic        enc_two_s;
    logic [31:0] enc_second_s;
    logic [31:0] li_sum_s;
    logic [4:0]  li_rd_s;
    logic        accept_s;

    assign li_sum_s = imm_in + 32'h0000_0800;
    assign li_rd_s  = base_instr_in[11:7];

    // Request side is free when idle, or when the final beat drains this cycle.
    assign req_ready_out = (state_r == IDLE) ||
                           ((state_r == OUT_LAST) && instr_ready_in);
    assign accept_s      = req_valid_in && req_ready_out;

    // Immediate field packing and LI expansion for the incoming request.
    always_comb begin
        enc_first_s  = base_instr_in;
        enc_err_s    = 1'b0;
        enc_two_s    = 1'b0;
        enc_second_s = 32'h0000_0000;
        case (imm_type_in)
            3'b010: begin
                enc_first_s = {imm_in[11:5], base_instr_in[24:12], imm_in[4:0], base_instr_in[6:0]};
                enc_err_s   = !upper_uniform(imm_in, 32'd11);
            end
            3'b011: begin
                enc_first_s = {imm_in[12], imm_in[10:5], base_instr_in[24:12],
                               imm_in[4:1], imm_in[11], base_instr_in[6:0]};
                enc_err_s   = !upper_uniform(imm_in, 32'd12) || imm_in[0];
            end
            3'b100: begin
                enc_first_s = {imm_in[31:12], base_instr_in[11:0]};
                enc_err_s   = (imm_in[11:0] != 12'h000);
            end
            3'b101: begin
                enc_first_s = {imm_in[20], imm_in[10:1], imm_in[11], imm_in[19:12],
                               base_instr_in[11:0]};
                enc_err_s   = !upper_uniform(imm_in, 32'd20) || imm_in[0];
            end
            3'b110: begin
                enc_first_s = {base_instr_in[31:20], imm_in[4:0], base_instr_in[14:0]};
                enc_err_s   = (imm_in[31:5] != 27'd0);
            end
            3'b111: begin
                if (LI_EN) begin
                    if (upper_uniform(imm_in, 32'd11)) begin
                        enc_first_s = {imm_in[11:0], 5'd0, 3'b000, li_rd_s, OPC_OP_IMM};
                    end else begin
                        // hi is rounded so that the sign-extended lo lands back on imm.
                        enc_first_s  = {li_sum_s[31:12], li_rd_s, OPC_LUI};
                        enc_second_s = {imm_in[11:0], li_rd_s, 3'b000, li_rd_s, OPC_OP_IMM};
                        enc_two_s    = (imm_in[11:0] != 12'h000);
                    end
                end else begin
                    enc_first_s = {imm_in[11:0], base_instr_in[19:0]};
                    enc_err_s   = !upper_uniform(imm_in, 32'd11);
                end
            end
            default: begin
                enc_first_s = {imm_in[11:0], base_instr_in[19:0]};
                enc_err_s   = !upper_uniform(imm_in, 32'd11);
            end
        endcase
    end

    // Next-state and next-output logic for the beat sequencer.
    always_comb begin
        state_s = state_r;
        valid_s = valid_r;
        instr_s = instr_r;
        last_s  = last_r;
        err_s   = err_r;
        pend_s  = pend_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    valid_s = 1'b1;
                    instr_s = enc_first_s;
                    err_s   = enc_err_s;
                    pend_s  = enc_second_s;
                    last_s  = !enc_two_s;
                    state_s = enc_two_s ? OUT_LUI : OUT_LAST;
                end else begin
                    valid_s = 1'b0;
                end
            end
            OUT_LUI: begin
                if (instr_ready_in) begin
                    instr_s = pend_r;
                    last_s  = 1'b1;
                    err_s   = 1'b0;
                    state_s = OUT_LAST;
                end else begin
                    state_s = OUT_LUI;
                end
            end
            OUT_LAST: begin
                if (accept_s) begin
                    valid_s = 1'b1;
                    instr_s = enc_first_s;
                    err_s   = enc_err_s;
                    pend_s  = enc_second_s;
                    last_s  = !enc_two_s;
                    state_s = enc_two_s ? OUT_LUI : OUT_LAST;
                end else if (instr_ready_in) begin
                    valid_s = 1'b0;
                    state_s = IDLE;
                end else begin
                    state_s = OUT_LAST;
                end
            end
            default: begin
                valid_s = 1'b0;
                state_s = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (ms_riscv32_mp_rst_in) begin
            state_r <= IDLE;
            valid_r <= 1'b0;
            instr_r <= 32'h0000_0000;
            last_r  <= 1'b0;
            err_r   <= 1'b0;
            pend_r  <= 32'h0000_0000;
        end else begin
            state_r <= state_s;
            valid_r <= valid_s;
            instr_r <= instr_s;
            last_r  <= last_s;
            err_r   <= err_s;
            pend_r  <= pend_s;
        end
    end

    assign instr_valid_out = valid_r;
    assign instr_out       = instr_r;
    assign instr_last_out  = last_r;
    assign range_err_out   = err_r;

endmodule
